ov7670_pixel_capture: RTL and testbench
=======================================

// Module: ov7670_pixel_capture
// PURPOSE
//  Assembles the OV7670 8-bit RGB444 byte stream (pclk domain) into 12-bit pixels.
//  Writes each pixel to the frame BRAM write port at a linear address 0..H_PIX*V_PIX-1.
//  The VGA read side scans that BRAM at the same addresses.
//  Discards SKIP_FRAMES frames after enable so the sensor's register settings have settled.
//  Reports completion and integrity of each frame.
// PARAMETERS
//  H_PIX        640  pixels per line (2 bytes per pixel)
//  V_PIX        480  lines per frame
//  SKIP_FRAMES  2    whole frames discarded after entering WAIT_VS (0 allowed)
//  ADDR_W       19   BRAM address width; must hold H_PIX*V_PIX-1
// PORTS
//  i_pclk        in   1       camera pixel clock; sole clock
//  i_rst_pclk    in   1       asynchronous reset, active-high
//  i_cap_en      in   1       capture enable (from config-done logic)
//  i_cam_vsync   in   1       OV7670 VSYNC, high during vertical blanking
//  i_cam_href    in   1       OV7670 HREF, high while line bytes are valid
//  i_cam_data    in   8       OV7670 D[7:0]
//  o_pix_wr      out  1       BRAM write enable, 1-cycle pulse per pixel
//  o_pix_addr    out  ADDR_W  BRAM write address
//  o_pix_data    out  12      {R[3:0],G[3:0],B[3:0]}
//  o_frame_done  out  1       1-cycle pulse at end of each captured frame
//  o_frame_ok    out  1       valid with o_frame_done; held until next o_frame_done
//  o_busy        out  1       high in any state except IDLE
// BEHAVIOUR
//  Input staging and edges
//   - vsync/href/data are registered once (stage s1); all logic uses s1 values.
//   - A second vsync register gives edge detection:
//     vs_rise = s1 & ~s2 (frame end); vs_fall = ~s1 & s2 (frame start).
//  Reset
//   - State=IDLE; all outputs 0; address, pixel/line counters, byte phase, skip count = 0.
//  FSM
//   - IDLE: o_busy=0. i_cap_en=1 -> WAIT_VS.
//   - WAIT_VS: wait for vs_rise; this guarantees no partial first frame.
//       On vs_rise: SKIP_FRAMES==0 -> CAPTURE, otherwise SKIP with skip_cnt=SKIP_FRAMES.
//   - SKIP: each vs_rise decrements skip_cnt; on the vs_rise that makes it 0 -> CAPTURE.
//       No writes occur in this state.
//   - CAPTURE: assembles and writes pixels. On each vs_rise:
//       pulse o_frame_done and update o_frame_ok.
//       If i_cap_en==0 at that cycle -> IDLE; otherwise stay in CAPTURE.
//   - i_cap_en deasserted in WAIT_VS or SKIP -> IDLE immediately.
//   - i_cap_en deasserted in CAPTURE finishes the current frame first.
//  Pixel assembly (CAPTURE only)
//   - Byte phase clears whenever s1 href==0.
//   - Phase 0 byte: latch R = data[3:0]; data[7:4] is ignored.
//   - Phase 1 byte: o_pix_data = {R, data[7:4], data[3:0]}.
//       o_pix_wr=1 on the next cycle, i.e. 2 pclk after the second byte is on the pins.
//   - Address: o_pix_addr holds the current write address during the o_pix_wr pulse.
//       It increments by 1 after each write and clears to 0 on vs_fall and on entry to CAPTURE.
//   - Overflow: once H_PIX*V_PIX pixels are written in a frame, further pixels are dropped.
//       No write, no address wrap; the frame is flagged bad.
//  Frame integrity (o_frame_ok=1 only if all of these hold)
//   - pixels written == H_PIX*V_PIX
//   - every line (href high period) held exactly 2*H_PIX bytes
//   - href lines counted == V_PIX
//   - An odd trailing byte in a line is discarded and marks the frame bad.
//  Simultaneous events
//   - Byte completion coincident with a vs_rise: the pixel is written first, then frame_done follows.
//   - The frame_done evaluation includes that pixel.
//  Reset mid-frame
//   - Asynchronous return to IDLE; any in-flight o_pix_wr is cancelled in the same instant.
// TESTING
//  1 Reset, cap_en=1, SKIP_FRAMES=2, 4 ideal 640x480 frames
//    -> no writes in frames 1-2; frames 3-4 each give 307200 writes at addr 0..307199.
//    -> frame_done with frame_ok=1 after each of frames 3 and 4.
//  2 Bytes 0x0A,0x5C on one pixel -> o_pix_data=12'hA5C, o_pix_wr 2 pclk after byte 2.
//  3 cap_en asserted mid-frame with SKIP_FRAMES=0
//    -> no writes until after the next vsync rise; the first captured frame starts at addr 0.
//  4 One line carries 1279 bytes -> that pixel is dropped; frame_ok=0.
//    -> The next clean frame gives frame_ok=1.
//  5 Frame with 481 lines -> exactly 307200 writes, last addr 307199, no wrap; frame_ok=0.
//  6 cap_en dropped mid-capture -> the frame completes with frame_done, then IDLE and o_busy=0.
//    -> Assert i_rst_pclk mid-line -> all outputs 0 immediately.

Source files
------------

// File: rtl/ov7670_pixel_capture.sv
// OV7670 RGB444 capture: pairs sensor bytes into 12-bit pixels and writes them
// to a linear frame buffer, skipping settle frames and flagging frame integrity.
module ov7670_pixel_capture #(
  parameter int H_PIX       = 640,
  parameter int V_PIX       = 480,
  parameter int SKIP_FRAMES = 2,
  parameter int ADDR_W      = 19
) (
  input  logic              i_pclk,
  input  logic              i_rst_pclk,
  input  logic              i_cap_en,
  input  logic              i_cam_vsync,
  input  logic              i_cam_href,
  input  logic [7:0]        i_cam_data,
  output logic              o_pix_wr,
  output logic [ADDR_W-1:0] o_pix_addr,
  output logic [11:0]       o_pix_data,
  output logic              o_frame_done,
  output logic              o_frame_ok,
  output logic              o_busy
);
  localparam int CW = ADDR_W + 1;
  localparam int BW = $clog2(2*H_PIX + 2);
  localparam int LW = $clog2(V_PIX + 2);
  localparam int SW = (SKIP_FRAMES > 0) ? $clog2(SKIP_FRAMES + 1) : 1;
  localparam logic [CW-1:0] PIX_TOT = CW'(H_PIX * V_PIX);
  localparam logic [BW-1:0] LINE_B  = BW'(2 * H_PIX);
  localparam logic [BW-1:0] BYTE_SAT = BW'(2 * H_PIX + 1);
  localparam logic [LW-1:0] LINES   = LW'(V_PIX);
  localparam logic [LW-1:0] LINE_SAT = LW'(V_PIX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, SKIP, CAPTURE} state_t;
  state_t state, state_n;

  logic          s1_vs, s2_vs, s1_href, s2_href;
  logic [7:0]    s1_data;
  logic [SW-1:0] skip_cnt;
  logic          phase;
  logic [3:0]    r_lat;
  logic [CW-1:0] pix_cnt;
  logic [BW-1:0] byte_cnt;
  logic [LW-1:0] line_cnt;
  logic          bad, end_pend;

  wire vs_rise  = s1_vs & ~s2_vs;
  wire vs_fall  = ~s1_vs & s2_vs;
  wire cap      = (state == CAPTURE);
  wire enter    = (state_n == CAPTURE) && !cap;
  wire frm_clr  = enter || (cap && vs_fall);
  wire pix_done = cap && s1_href && phase;
  wire room     = (pix_cnt < PIX_TOT);
  wire line_end = cap && s2_href && !s1_href;

  always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
    if (i_rst_pclk) begin
      s1_vs <= 1'b0; s2_vs <= 1'b0; s1_href <= 1'b0; s2_href <= 1'b0; s1_data <= '0;
    end else begin
      s1_vs <= i_cam_vsync; s2_vs <= s1_vs;
      s1_href <= i_cam_href; s2_href <= s1_href;
      s1_data <= i_cam_data;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (i_cap_en) state_n = WAIT_VS;
      WAIT_VS: if (!i_cap_en) state_n = IDLE;
               else if (vs_rise) state_n = (SKIP_FRAMES == 0) ? CAPTURE : SKIP;
      SKIP:    if (!i_cap_en) state_n = IDLE;
               else if (vs_rise && skip_cnt == SW'(1)) state_n = CAPTURE;
      CAPTURE: if (vs_rise && !i_cap_en) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
    if (i_rst_pclk) begin
      state    <= IDLE;
      skip_cnt <= '0;
    end else begin
      state <= state_n;
      if (state == WAIT_VS && vs_rise) skip_cnt <= SW'(SKIP_FRAMES);
      else if (state == SKIP && vs_rise) skip_cnt <= skip_cnt - SW'(1);
    end
  end

  // Frame-end evaluation runs one cycle after vs_rise so a pixel completing on
  // that same cycle is already counted.
  always_ff @(posedge i_pclk or posedge i_rst_pclk) begin
    if (i_rst_pclk) begin
      phase <= 1'b0; r_lat <= '0; o_pix_wr <= 1'b0; o_pix_data <= '0; o_pix_addr <= '0;
      pix_cnt <= '0; byte_cnt <= '0; line_cnt <= '0; bad <= 1'b0; end_pend <= 1'b0;
      o_frame_done <= 1'b0; o_frame_ok <= 1'b0;
    end else begin
      phase <= cap && s1_href && !phase;
      if (cap && s1_href && !phase) r_lat <= s1_data[3:0];
      o_pix_wr <= pix_done && room;
      if (pix_done && room) o_pix_data <= {r_lat, s1_data};

      if (frm_clr) o_pix_addr <= '0;
      else if (o_pix_wr) o_pix_addr <= o_pix_addr + ADDR_W'(1);

      if (frm_clr) pix_cnt <= '0;
      else if (pix_done && room) pix_cnt <= pix_cnt + CW'(1);

      if (!cap || !s1_href) byte_cnt <= '0;
      else if (byte_cnt != BYTE_SAT) byte_cnt <= byte_cnt + BW'(1);

      if (frm_clr) line_cnt <= '0;
      else if (line_end && line_cnt != LINE_SAT) line_cnt <= line_cnt + LW'(1);

      if (frm_clr) bad <= 1'b0;
      else if ((line_end && byte_cnt != LINE_B) || (pix_done && !room)) bad <= 1'b1;

      end_pend     <= cap && vs_rise;
      o_frame_done <= end_pend;
      if (end_pend) o_frame_ok <= !bad && (pix_cnt == PIX_TOT) && (line_cnt == LINES);
    end
  end

  assign o_busy = (state != IDLE);
endmodule

// File: tb/tb_ov7670_pixel_capture.sv
// Bench for ov7670_pixel_capture: two instances (SKIP_FRAMES=2 and 0) share one
// random camera stream; a frame-level model predicts writes and frame results.
module tb_ov7670_pixel_capture;
  localparam int H  = 4;
  localparam int V  = 3;
  localparam int HV = H * V;
  localparam int AW = 4;

  logic clk = 1'b0;
  logic rst, cap_en, vsync, href;
  logic [7:0] data;
  logic          pix_wr   [2];
  logic [AW-1:0] pix_addr [2];
  logic [11:0]   pix_data [2];
  logic          frame_done [2];
  logic          frame_ok   [2];
  logic          busy       [2];

  always #5 clk = ~clk;

  ov7670_pixel_capture #(.H_PIX(H), .V_PIX(V), .SKIP_FRAMES(2), .ADDR_W(AW)) dut_skip2 (
    .i_pclk(clk), .i_rst_pclk(rst), .i_cap_en(cap_en), .i_cam_vsync(vsync),
    .i_cam_href(href), .i_cam_data(data), .o_pix_wr(pix_wr[0]), .o_pix_addr(pix_addr[0]),
    .o_pix_data(pix_data[0]), .o_frame_done(frame_done[0]), .o_frame_ok(frame_ok[0]),
    .o_busy(busy[0]));

  ov7670_pixel_capture #(.H_PIX(H), .V_PIX(V), .SKIP_FRAMES(0), .ADDR_W(AW)) dut_skip0 (
    .i_pclk(clk), .i_rst_pclk(rst), .i_cap_en(cap_en), .i_cam_vsync(vsync),
    .i_cam_href(href), .i_cam_data(data), .o_pix_wr(pix_wr[1]), .o_pix_addr(pix_addr[1]),
    .o_pix_data(pix_data[1]), .o_frame_done(frame_done[1]), .o_frame_ok(frame_ok[1]),
    .o_busy(busy[1]));

  int checks = 0, errors = 0, cyc = 0, byte2_cyc = 0;
  logic [AW+11:0] exp_wr [2][$];
  bit             exp_done [2][$];
  int mstate[2], rises[2];
  int nwr[2], ndone[2], last_addr[2], first_cyc[2];
  logic [11:0] first_data[2];
  bit last_ok[2];

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every write and frame_done must match the model's next entry.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (pix_wr[i] === 1'b1) begin
        checks++;
        if (exp_wr[i].size() == 0) begin
          errors++;
          $display("FAIL wr_unexpected inst%0d: got addr %0d data %h, required no write", i, pix_addr[i], pix_data[i]);
        end else begin
          logic [AW+11:0] e;
          e = exp_wr[i].pop_front();
          if ({pix_addr[i], pix_data[i]} !== e) begin
            errors++;
            $display("FAIL wr_value inst%0d: got addr %0d data %h, required addr %0d data %h",
                     i, pix_addr[i], pix_data[i], e[AW+11:12], e[11:0]);
          end
        end
        nwr[i]++; last_addr[i] = pix_addr[i];
        if (pix_addr[i] == 0) begin first_data[i] = pix_data[i]; first_cyc[i] = cyc; end
      end
      if (frame_done[i] === 1'b1) begin
        checks++;
        if (exp_done[i].size() == 0) begin
          errors++;
          $display("FAIL done_unexpected inst%0d: got frame_done ok=%0b, required none", i, frame_ok[i]);
        end else begin
          bit e;
          e = exp_done[i].pop_front();
          if (frame_ok[i] !== e) begin
            errors++;
            $display("FAIL frame_ok inst%0d: got %0b, required %0b", i, frame_ok[i], e);
          end
        end
        ndone[i]++; last_ok[i] = frame_ok[i];
      end
    end
  end

  // Reference model, frame granularity: 0 idle, 1 counting vsync rises, 2 capturing.
  function automatic int skip_of(input int i);
    return (i == 0) ? 2 : 0;
  endfunction

  function automatic void model_rise(input bit ok);
    for (int i = 0; i < 2; i++) begin
      if (mstate[i] == 2) begin
        exp_done[i].push_back(ok);
        if (!cap_en) mstate[i] = 0;
      end else if (mstate[i] == 1) begin
        rises[i]++;
        if (rises[i] >= skip_of(i) + 1) mstate[i] = 2;
      end
    end
  endfunction

  task automatic set_en(input bit v);
    @(negedge clk);
    cap_en = v;
    for (int i = 0; i < 2; i++) begin
      if (v && mstate[i] == 0) begin mstate[i] = 1; rises[i] = 0; end
      if (!v && mstate[i] != 2) mstate[i] = 0;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic send_frame(input int nlines, input int odd_line, input bit fixed,
                            input int en_line, input bit en_val);
    bit capt[2];
    int total, len;
    bit ok;
    logic [7:0] b, b0;
    for (int i = 0; i < 2; i++) capt[i] = (mstate[i] == 2);
    @(negedge clk); vsync = 1'b0;
    repeat (3) @(negedge clk);
    total = 0; ok = (nlines == V); b0 = 8'h00;
    for (int l = 0; l < nlines; l++) begin
      if (l == en_line) set_en(en_val);
      len = (l == odd_line) ? 2*H - 1 : 2*H;
      if (len != 2*H) ok = 1'b0;
      for (int k = 0; k < len; k++) begin
        @(negedge clk);
        b = 8'($urandom);
        if (fixed && l == 0 && k == 0) b = 8'h0A;
        if (fixed && l == 0 && k == 1) b = 8'h5C;
        href = 1'b1; data = b;
        if (k % 2 == 0) b0 = b;
        else begin
          if (fixed && l == 0 && k == 1) byte2_cyc = cyc;
          if (total < HV)
            for (int i = 0; i < 2; i++)
              if (capt[i]) exp_wr[i].push_back({AW'(total), b0[3:0], b});
          total++;
        end
      end
      @(negedge clk); href = 1'b0;
      repeat (2) @(negedge clk);
    end
    if (total != HV) ok = 1'b0;
    @(negedge clk); vsync = 1'b1;
    model_rise(ok);
    repeat (8) @(negedge clk);
  endtask

  task automatic test_reset;
    rst = 1'b1; cap_en = 1'b0; vsync = 1'b0; href = 1'b0; data = 8'h00;
    for (int i = 0; i < 2; i++) begin mstate[i] = 0; rises[i] = 0; end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pix_wr[i], pix_addr[i], pix_data[i], frame_done[i], frame_ok[i], busy[i]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs inst%0d: got wr=%b addr=%h data=%h done=%b ok=%b busy=%b, required all 0",
                 i, pix_wr[i], pix_addr[i], pix_data[i], frame_done[i], frame_ok[i], busy[i]);
      end
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_skip_frames;
    int w0[2], d0[2];
    set_en(1'b1);
    @(negedge clk); vsync = 1'b1;
    model_rise(1'b0);
    repeat (6) @(negedge clk);
    for (int i = 0; i < 2; i++) begin w0[i] = nwr[i]; d0[i] = ndone[i]; end
    send_frame(V, -1, 0, -1, 0);
    send_frame(V, -1, 0, -1, 0);
    checks++;
    if (nwr[0] - w0[0] != 0) begin
      errors++; $display("FAIL skip_no_writes: got %0d writes, required 0", nwr[0] - w0[0]);
    end
    send_frame(V, -1, 0, -1, 0);
    send_frame(V, -1, 0, -1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (nwr[i] - w0[i] != (i == 0 ? 2 : 4) * HV) begin
        errors++; $display("FAIL frame_writes inst%0d: got %0d, required %0d", i, nwr[i] - w0[i], (i == 0 ? 2 : 4) * HV);
      end
      checks++;
      if (ndone[i] - d0[i] != (i == 0 ? 2 : 4) || last_ok[i] !== 1'b1) begin
        errors++; $display("FAIL frame_done_count inst%0d: got %0d ok=%0b, required %0d ok=1", i, ndone[i] - d0[i], last_ok[i], (i == 0 ? 2 : 4));
      end
      checks++;
      if (last_addr[i] != HV - 1 || exp_wr[i].size() != 0) begin
        errors++; $display("FAIL last_addr inst%0d: got %0d pending %0d, required %0d pending 0", i, last_addr[i], exp_wr[i].size(), HV - 1);
      end
    end
  endtask

  task automatic test_pixel_format;
    send_frame(V, -1, 1, -1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (first_data[i] !== 12'hA5C) begin
        errors++; $display("FAIL pixel_pack inst%0d: got %h, required a5c", i, first_data[i]);
      end
      checks++;
      if (first_cyc[i] - byte2_cyc != 2) begin
        errors++; $display("FAIL wr_latency inst%0d: got %0d cycles, required 2", i, first_cyc[i] - byte2_cyc);
      end
    end
  endtask

  task automatic test_odd_line;
    int w0[2];
    for (int i = 0; i < 2; i++) w0[i] = nwr[i];
    send_frame(V, 1, 0, -1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (nwr[i] - w0[i] != HV - 1 || last_ok[i] !== 1'b0) begin
        errors++; $display("FAIL odd_line inst%0d: got %0d writes ok=%0b, required %0d ok=0", i, nwr[i] - w0[i], last_ok[i], HV - 1);
      end
    end
    send_frame(V, -1, 0, -1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (last_ok[i] !== 1'b1) begin
        errors++; $display("FAIL recover_ok inst%0d: got %0b, required 1", i, last_ok[i]);
      end
    end
  endtask

  task automatic test_extra_line;
    int w0[2];
    for (int i = 0; i < 2; i++) w0[i] = nwr[i];
    send_frame(V + 1, -1, 0, -1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (nwr[i] - w0[i] != HV || last_addr[i] != HV - 1 || last_ok[i] !== 1'b0) begin
        errors++; $display("FAIL overflow inst%0d: got %0d writes last %0d ok=%0b, required %0d last %0d ok=0",
                           i, nwr[i] - w0[i], last_addr[i], last_ok[i], HV, HV - 1);
      end
    end
  endtask

  task automatic test_enable_drop;
    int w0[2], d0[2];
    for (int i = 0; i < 2; i++) begin w0[i] = nwr[i]; d0[i] = ndone[i]; end
    send_frame(V, -1, 0, 1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (ndone[i] - d0[i] != 1 || last_ok[i] !== 1'b1 || nwr[i] - w0[i] != HV) begin
        errors++; $display("FAIL drop_finish inst%0d: got done %0d ok=%0b writes %0d, required 1 ok=1 %0d",
                           i, ndone[i] - d0[i], last_ok[i], nwr[i] - w0[i], HV);
      end
      checks++;
      if (busy[i] !== 1'b0) begin
        errors++; $display("FAIL drop_idle inst%0d: got busy %b, required 0", i, busy[i]);
      end
      w0[i] = nwr[i];
    end
    send_frame(V, -1, 0, -1, 0);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (nwr[i] - w0[i] != 0) begin
        errors++; $display("FAIL idle_writes inst%0d: got %0d, required 0", i, nwr[i] - w0[i]);
      end
    end
  endtask

  task automatic test_midframe_enable;
    int w0[2];
    for (int i = 0; i < 2; i++) w0[i] = nwr[i];
    send_frame(V, -1, 0, 1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (nwr[i] - w0[i] != 0 || busy[i] !== 1'b1) begin
        errors++; $display("FAIL partial_frame inst%0d: got %0d writes busy %b, required 0 busy 1", i, nwr[i] - w0[i], busy[i]);
      end
      w0[i] = nwr[i];
    end
    send_frame(V, -1, 0, -1, 0);
    checks++;
    if (nwr[1] - w0[1] != HV || last_addr[1] != HV - 1 || last_ok[1] !== 1'b1) begin
      errors++; $display("FAIL first_capture: got %0d writes last %0d ok=%0b, required %0d last %0d ok=1",
                         nwr[1] - w0[1], last_addr[1], last_ok[1], HV, HV - 1);
    end
    checks++;
    if (nwr[0] - w0[0] != 0) begin
      errors++; $display("FAIL skip_after_enable: got %0d writes, required 0", nwr[0] - w0[0]);
    end
  endtask

  task automatic test_reset_midline;
    logic [7:0] b, b0;
    b0 = 8'h00;
    @(negedge clk); vsync = 1'b0;
    repeat (3) @(negedge clk);
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      b = 8'($urandom);
      href = 1'b1; data = b;
      if (k % 2 == 0) b0 = b;
      else if (k < 5) exp_wr[1].push_back({AW'(k / 2), b0[3:0], b});
    end
    checks++;
    if (pix_wr[1] !== 1'b1 || busy[1] !== 1'b1) begin
      errors++; $display("FAIL inflight_write: got wr %b busy %b, required 1 1", pix_wr[1], busy[1]);
    end
    #1 rst = 1'b1;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if ({pix_wr[i], pix_addr[i], pix_data[i], frame_done[i], frame_ok[i], busy[i]} !== '0) begin
        errors++; $display("FAIL async_reset inst%0d: got wr=%b addr=%h data=%h done=%b ok=%b busy=%b, required all 0",
                           i, pix_wr[i], pix_addr[i], pix_data[i], frame_done[i], frame_ok[i], busy[i]);
      end
    end
    checks++;
    if (exp_wr[1].size() != 0) begin
      errors++; $display("FAIL midline_writes: got %0d pending, required 0", exp_wr[1].size());
    end
    cap_en = 1'b0; href = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin nwr[i] = 0; ndone[i] = 0; last_addr[i] = 0; first_cyc[i] = 0; last_ok[i] = 0; first_data[i] = '0; end
    test_reset;
    test_skip_frames;
    test_pixel_format;
    test_odd_line;
    test_extra_line;
    test_enable_drop;
    test_midframe_enable;
    test_reset_midline;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
